// File: rtl/jag_dram_pager.sv
`default_nettype none
// ============================================================================
// jag_dram_pager : open-page row tracker, command sequencer and refresh owner
//                  for the Jaguar DRAM channel (ch1).
// Revision       : 1.0
// ============================================================================
module jag_dram_pager #(
  parameter int T_PCH        = 4,
  parameter int T_ACT        = 4,
  parameter int T_RD         = 12,
  parameter int T_WR         = 8,
  parameter int T_REF        = 10,
  parameter int REF_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [20:0] host_addr,
  input  logic [63:0] host_din,
  input  logic [7:0]  host_be,
  input  logic        host_64,
  output logic [63:0] host_dout,
  output logic        host_valid,
  output logic        host_busy,
  output logic [7:0]  ch1_addr,
  output logic [12:0] ch1_caddr,
  output logic [63:0] ch1_din,
  output logic [7:0]  ch1_be,
  output logic        ch1_64,
  output logic        ch1_rnw,
  output logic        ch1_reqr,
  output logic        ch1_reqw,
  output logic        ch1_act,
  output logic        ch1_pch,
  output logic        ch1_ref,
  input  logic [63:0] ch1_dout
);

  localparam int RW = $clog2(REF_INTERVAL + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PCH_WAIT = 3'd1,
    ACT_WAIT = 3'd2,
    RD_WAIT  = 3'd3,
    WR_WAIT  = 3'd4,
    REF_WAIT = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   wait_cnt, wait_nxt;
  logic [RW-1:0] ref_cnt;
  logic          row_open, ref_pend;
  logic [12:0]   open_row;
  logic          req_wr, req_64;
  logic [20:0]   req_addr;
  logic [63:0]   req_din;
  logic [7:0]    req_be;

  logic ref_due, row_hit, wait_done;
  logic do_pch, do_act, do_ref, do_rd, do_wr, do_done, pch_exit, set_ref_pend;

  assign ref_due   = (ref_cnt == RW'(REF_INTERVAL));
  assign row_hit   = (open_row == req_addr[20:8]);
  assign wait_done = (wait_cnt == 16'd0);

  always_comb begin
    state_nxt    = state;
    do_pch       = 1'b0;
    do_act       = 1'b0;
    do_ref       = 1'b0;
    do_rd        = 1'b0;
    do_wr        = 1'b0;
    do_done      = 1'b0;
    pch_exit     = 1'b0;
    set_ref_pend = 1'b0;
    case (state)
      IDLE: begin
        // refresh outranks any pending host request
        if (ref_due && row_open) begin
          do_pch       = 1'b1;
          set_ref_pend = 1'b1;
        end else if (ref_due) begin
          do_ref = 1'b1;
        end else if (host_busy) begin
          if (row_open && row_hit) begin
            do_rd = !req_wr;
            do_wr = req_wr;
          end else if (row_open) begin
            do_pch = 1'b1;
          end else begin
            do_act = 1'b1;
          end
        end
      end
      PCH_WAIT: if (wait_done) begin
        pch_exit = 1'b1;
        if (ref_pend) do_ref = 1'b1;
        else          do_act = 1'b1;
      end
      ACT_WAIT: if (wait_done) begin
        do_rd = !req_wr;
        do_wr = req_wr;
      end
      RD_WAIT, WR_WAIT: if (wait_done) begin
        do_done   = 1'b1;
        state_nxt = IDLE;
      end
      REF_WAIT: if (wait_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    if (do_pch) state_nxt = PCH_WAIT;
    if (do_act) state_nxt = ACT_WAIT;
    if (do_ref) state_nxt = REF_WAIT;
    if (do_rd)  state_nxt = RD_WAIT;
    if (do_wr)  state_nxt = WR_WAIT;

    if (do_pch)                wait_nxt = 16'(T_PCH - 1);
    else if (do_act)           wait_nxt = 16'(T_ACT - 1);
    else if (do_ref)           wait_nxt = 16'(T_REF - 1);
    else if (do_rd)            wait_nxt = 16'(T_RD - 1);
    else if (do_wr)            wait_nxt = 16'(T_WR - 1);
    else if (!wait_done)       wait_nxt = wait_cnt - 16'd1;
    else                       wait_nxt = wait_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      ref_cnt    <= '0;
      row_open   <= 1'b0;
      ref_pend   <= 1'b0;
      open_row   <= '0;
      req_wr     <= 1'b0;
      req_64     <= 1'b0;
      req_addr   <= '0;
      req_din    <= '0;
      req_be     <= '0;
      host_dout  <= '0;
      host_valid <= 1'b0;
      host_busy  <= 1'b0;
      ch1_addr   <= '0;
      ch1_caddr  <= '0;
      ch1_din    <= '0;
      ch1_be     <= '0;
      ch1_64     <= 1'b0;
      ch1_rnw    <= 1'b0;
      ch1_reqr   <= 1'b0;
      ch1_reqw   <= 1'b0;
      ch1_act    <= 1'b0;
      ch1_pch    <= 1'b0;
      ch1_ref    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;

      if (do_ref)        ref_cnt <= '0;
      else if (!ref_due) ref_cnt <= ref_cnt + RW'(1);

      if (set_ref_pend) ref_pend <= 1'b1;
      else if (do_ref)  ref_pend <= 1'b0;

      if (pch_exit) row_open <= 1'b0;
      if (do_act) begin
        row_open <= 1'b1;
        open_row <= req_addr[20:8];
      end

      if (host_req && !host_busy) begin
        req_wr    <= host_wr;
        req_addr  <= host_addr;
        req_din   <= host_din;
        req_be    <= host_be;
        req_64    <= host_64;
        host_busy <= 1'b1;
      end else if (do_done) begin
        host_busy <= 1'b0;
      end

      ch1_pch    <= do_pch;
      ch1_act    <= do_act;
      ch1_ref    <= do_ref;
      ch1_reqr   <= do_rd;
      ch1_reqw   <= do_wr;
      host_valid <= do_done;

      if (do_done && !req_wr) host_dout <= ch1_dout;
      if (do_act) ch1_caddr <= req_addr[20:8];
      if (do_rd) begin
        ch1_rnw  <= 1'b1;
        ch1_addr <= req_addr[7:0];
        ch1_64   <= req_64;
      end
      if (do_wr) begin
        ch1_rnw   <= 1'b0;
        ch1_caddr <= {5'b0, req_addr[7:0]};
        ch1_din   <= req_din;
        ch1_be    <= req_be;
        ch1_64    <= req_64;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/jag_dram_pager.md
# jag_dram_pager

Page-management front end for the Jaguar DRAM channel (ch1) of the dual-channel SDRAM controller. It accepts simple host read and write requests carrying a flat 64-bit-word address. It tracks the single open row and emits the ch1 precharge, activate, read, write and refresh pulses in the correct order. It returns read data after fixed, parameterised latencies and owns periodic refresh for ch1, so the controller may run with self_refresh=0.

## Interface
Parameters:
- T_PCH, 4: cycles from ch1_pch pulse to next command
- T_ACT, 4: cycles from ch1_act pulse to read/write pulse
- T_RD, 12: cycles from ch1_reqr pulse to ch1_dout capture
- T_WR, 8: cycles from ch1_reqw pulse to completion
- T_REF, 10: cycles from ch1_ref pulse to next command
- REF_INTERVAL, 780: cycles between refresh requests

Ports:
- clk, in, 1: single clock, shared with the SDRAM controller
- reset_n, in, 1: asynchronous active-low reset
- host_req, in, 1: request strobe; sampled only while host_busy=0
- host_wr, in, 1: 1 = write, 0 = read
- host_addr, in, 21: 64-bit-word address; [20:8] = row, [7:0] = column
- host_din, in, 64: write data
- host_be, in, 8: byte enables, active high
- host_64, in, 1: 1 = 64-bit access, 0 = 32-bit access
- host_dout, out, 64: read data, valid with host_valid
- host_valid, out, 1: one-cycle completion pulse for reads and writes
- host_busy, out, 1: request in progress
- ch1_addr, out, 8: read column
- ch1_caddr, out, 13: row during activate; {5'b0, column} otherwise
- ch1_din, out, 64: write data
- ch1_be, out, 8: byte enables
- ch1_64, out, 1: width select
- ch1_rnw, out, 1: 1 = read
- ch1_reqr, ch1_reqw, ch1_act, ch1_pch, ch1_ref, out, 1 each: one-cycle command pulses
- ch1_dout, in, 64: read data from the controller

## Operation
- All outputs are registered. On reset:
  - every output is 0, including host_dout and all ch1 data/address buses
  - row_open=0, open_row=0, ref_cnt=0, wait counter=0, state IDLE
- Accept: at a clock edge with host_req=1 and host_busy=0, latch wr, addr, din, be and 64, and set host_busy=1.
  - host_req while host_busy=1 is ignored; it is neither queued nor flagged.
- ref_cnt increments every cycle and saturates at REF_INTERVAL. ref_due = (ref_cnt == REF_INTERVAL). ref_cnt is cleared at the edge that issues ch1_ref.
- States: IDLE, PCH_WAIT, ACT_WAIT, RD_WAIT, WR_WAIT, REF_WAIT. Each command edge loads wait_cnt = T_x−1. A WAIT state exits at the edge where wait_cnt==0, so every WAIT state lasts exactly T_x cycles.
- IDLE priority, evaluated each edge:
  1. ref_due with row_open: pulse ch1_pch → PCH_WAIT, then ref-pending.
  2. ref_due with row closed: pulse ch1_ref → REF_WAIT.
  3. Pending request with row_open and matching row: issue the access (see below).
  4. Pending request with row_open and a different row: pulse ch1_pch → PCH_WAIT.
  5. Pending request with row closed: pulse ch1_act with ch1_caddr=row, set row_open=1 and open_row=row → ACT_WAIT.
- PCH_WAIT exit: clear row_open. If ref-pending, pulse ch1_ref → REF_WAIT. Otherwise pulse ch1_act for the pending row → ACT_WAIT.
- ACT_WAIT exit: issue the access directly; the FSM does not return to IDLE in between.
- Access:
  - Read: ch1_reqr=1, ch1_rnw=1, ch1_addr=column → RD_WAIT.
  - Write: ch1_reqw=1, ch1_rnw=0, ch1_caddr={5'b0, column}, ch1_din, ch1_be → WR_WAIT.
  - ch1_64 is driven from the latched width for both.
- RD_WAIT exit: host_dout <= ch1_dout, host_valid=1, host_busy=0 → IDLE.
- WR_WAIT exit: host_valid=1, host_busy=0 → IDLE.
- REF_WAIT exit → IDLE with row closed. The controller also drops its own active flag on ch1_ref.
- A refresh that falls due mid-access waits until the FSM returns to IDLE. Refresh then preempts any pending request, including one accepted on that same edge.
- The row stays open after an access (open-page policy). Only a row miss or a refresh closes it.
- Data buses hold their last value between commands.

## Timing
- Edge E0 accepts the request; host_busy=1 from then on.
- Read with row closed:
  - ch1_act after E1
  - ch1_reqr after E1+T_ACT
  - host_valid after E1+T_ACT+T_RD (E17 with defaults)
- Read row hit: ch1_reqr after E1, host_valid after E13.
- Read row miss: ch1_pch after E1, ch1_act after E5, ch1_reqr after E9, host_valid after E21.
- Write row hit: host_valid after E1+T_WR (E9).
- A new request may be accepted at the same edge that sets host_busy=0. The next accept is therefore possible one cycle after host_valid.
- Refresh with row open: ch1_pch, then ch1_ref T_PCH cycles later, then IDLE T_REF cycles after that.
- Each command pulse is exactly one cycle wide. No two command pulses occur in the same cycle.

## Test plan
- Reset release, then a read of row 0x012, column 0x34 with ch1_dout=64'hDEADBEEF_01234567:
  - ch1_act with caddr=0x012 after E1, ch1_reqr with ch1_addr=0x34 after E5
  - host_valid for one cycle after E17 with that data; host_busy low in the same cycle
- Second read to the same row at column 0x35:
  - no ch1_act and no ch1_pch
  - ch1_reqr after E1, host_valid after E13
- Write to row 0x013 while row 0x012 is open, host_be=8'h0F, host_din=64'h1122334455667788:
  - ch1_pch, then ch1_act (caddr=0x013) 4 cycles later, then ch1_reqw (caddr[7:0]=column, be=0x0F) 4 cycles after that
  - host_valid 8 cycles after ch1_reqw
- Idle for 780+ cycles with a row open:
  - ch1_pch, then ch1_ref 4 cycles later, ref_cnt cleared
  - the next access issues ch1_act (row closed)
- host_req on the same edge that ref_due is true:
  - refresh sequence completes first, then the request runs as a closed-row access
  - host_busy stays high throughout
- reset_n asserted during RD_WAIT:
  - all outputs 0 immediately; no host_valid afterwards
  - the first request after release starts with ch1_act
